fetch_unit: RTL and testbench

- Consumer end of the program-counter interface: accepts fetch requests (address from the PC block) and drives a valid/ready instruction-memory port.
- Pairs each in-order memory response with its PC and buffers the pair for decode.
- Supports flush/redirect by discarding in-flight responses.
- Sits between the PC block and instruction decode in the pipelined core.

---
 rtl/fetch_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: consumer end of the PC interface.
// Issues fetch requests to instruction memory and pairs each in-order response
// with its PC. The pairs are buffered for decode. Flush discards buffered
// entries and drops responses that are still in flight.
module fetch_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2,
   parameter int CNT_W      = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [DATA_WIDTH-1:0] req_pc,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [DATA_WIDTH-1:0] mem_addr,
   input  logic                  mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [DATA_WIDTH-1:0] instr_pc
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W:0]   OCC_LIMIT = (CNT_W + 1)'(DEPTH);

   // PCs of issued requests, waiting for their responses
   logic [DATA_WIDTH-1:0] pcq_mem [DEPTH];
   // Completed {pc, instr} pairs, waiting for decode
   logic [DATA_WIDTH-1:0] outq_pc_mem    [DEPTH];
   logic [DATA_WIDTH-1:0] outq_instr_mem [DEPTH];

   logic [PTR_W-1:0] pcq_wr_reg,  pcq_wr_next;
   logic [PTR_W-1:0] pcq_rd_reg,  pcq_rd_next;
   logic [PTR_W-1:0] outq_wr_reg, outq_wr_next;
   logic [PTR_W-1:0] outq_rd_reg, outq_rd_next;
   logic [CNT_W-1:0] inflight_reg, inflight_next;
   logic [CNT_W-1:0] out_cnt_reg,  out_cnt_next;
   logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;

   logic [CNT_W:0] occupancy;
   logic           credit_ok;
   logic           issue;
   logic           out_push;
   logic           out_pop;

   // Dropped entries still hold credit, so every response always has a slot
   assign occupancy     = {1'b0, inflight_reg} + {1'b0, out_cnt_reg};
   assign credit_ok     = occupancy < OCC_LIMIT;
   assign req_ready     = mem_req_ready & credit_ok & ~flush;
   assign mem_req_valid = req_valid & credit_ok & ~flush & rst;
   assign mem_addr      = req_pc;
   assign issue         = req_valid & req_ready;

   assign out_push    = mem_rsp_valid & ~flush & (drop_cnt_reg == '0);
   assign out_pop     = instr_valid & instr_ready & ~flush;
   assign instr_valid = (out_cnt_reg != '0);
   // Head entry comes straight from storage flops; forced to 0 when empty
   assign instr       = instr_valid ? outq_instr_mem[outq_rd_reg] : '0;
   assign instr_pc    = instr_valid ? outq_pc_mem[outq_rd_reg]    : '0;

   // Next-state for pointers and occupancy counters
   always_comb begin
      pcq_wr_next   = pcq_wr_reg;
      pcq_rd_next   = pcq_rd_reg;
      outq_wr_next  = outq_wr_reg;
      outq_rd_next  = outq_rd_reg;
      inflight_next = inflight_reg;
      out_cnt_next  = out_cnt_reg;
      drop_cnt_next = drop_cnt_reg;

      if (issue)
         pcq_wr_next = pcq_wr_reg + PTR_ONE;
      if (mem_rsp_valid)
         pcq_rd_next = pcq_rd_reg + PTR_ONE;

      case ({issue, mem_rsp_valid})
         2'b10:   inflight_next = inflight_reg + CNT_ONE;
         2'b01:   inflight_next = inflight_reg - CNT_ONE;
         default: inflight_next = inflight_reg;
      endcase

      if (flush) begin
         // Empty the output queue; everything still outstanding gets dropped
         out_cnt_next  = '0;
         outq_rd_next  = outq_wr_reg;
         drop_cnt_next = mem_rsp_valid ? (inflight_reg - CNT_ONE) : inflight_reg;
      end else begin
         if (mem_rsp_valid && (drop_cnt_reg != '0))
            drop_cnt_next = drop_cnt_reg - CNT_ONE;
         if (out_push)
            outq_wr_next = outq_wr_reg + PTR_ONE;
         if (out_pop)
            outq_rd_next = outq_rd_reg + PTR_ONE;
         case ({out_push, out_pop})
            2'b10:   out_cnt_next = out_cnt_reg + CNT_ONE;
            2'b01:   out_cnt_next = out_cnt_reg - CNT_ONE;
            default: out_cnt_next = out_cnt_reg;
         endcase
      end
   end

   // Control state register with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pcq_wr_reg   <= '0;
         pcq_rd_reg   <= '0;
         outq_wr_reg  <= '0;
         outq_rd_reg  <= '0;
         inflight_reg <= '0;
         out_cnt_reg  <= '0;
         drop_cnt_reg <= '0;
      end else begin
         pcq_wr_reg   <= pcq_wr_next;
         pcq_rd_reg   <= pcq_rd_next;
         outq_wr_reg  <= outq_wr_next;
         outq_rd_reg  <= outq_rd_next;
         inflight_reg <= inflight_next;
         out_cnt_reg  <= out_cnt_next;
         drop_cnt_reg <= drop_cnt_next;
      end
   end

   // Queue storage; contents are qualified by the counters, so no reset needed
   always_ff @(posedge clk) begin
      if (issue)
         pcq_mem[pcq_wr_reg] <= req_pc;
      if (out_push) begin
         outq_pc_mem[outq_wr_reg]    <= pcq_mem[pcq_rd_reg];
         outq_instr_mem[outq_wr_reg] <= mem_rdata;
      end
   end

`ifndef SYNTHESIS
   // Protocol checks: no response without a request; credit never overrun
   always_ff @(posedge clk) begin
      if (rst) begin
         assert (!(mem_rsp_valid && (inflight_reg == '0)));
         assert (occupancy <= OCC_LIMIT);
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed-vector bench for fetch_unit (DEPTH=2).
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_pc;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   int checks   = 0;
   int failures = 0;

   fetch_unit #(.DATA_WIDTH(32), .DEPTH(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_pc        (req_pc),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_addr      (mem_addr),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rdata     (mem_rdata),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr         (instr),
      .instr_pc      (instr_pc)
   );

   // 10-unit clock period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s = 0x%08h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] ins);
      check_eq({tag, ".valid"}, {31'b0, instr_valid}, 32'd1);
      check_eq({tag, ".pc"}, instr_pc, pc);
      check_eq({tag, ".instr"}, instr, ins);
   endtask

   task automatic check_empty(input string tag);
      check_eq({tag, ".valid"}, {31'b0, instr_valid}, 32'd0);
      check_eq({tag, ".instr"}, instr, 32'd0);
      check_eq({tag, ".pc"}, instr_pc, 32'd0);
   endtask

   // One-cycle request with the given pc
   task automatic issue_req(input logic [31:0] pc);
      req_valid = 1'b1;
      req_pc    = pc;
      tick();
      req_valid = 1'b0;
   endtask

   // One-cycle memory response
   task automatic respond(input logic [31:0] data);
      mem_rsp_valid = 1'b1;
      mem_rdata     = data;
      tick();
      mem_rsp_valid = 1'b0;
   endtask

   initial begin
      rst           = 1'b0;
      flush         = 1'b0;
      req_valid     = 1'b1;
      req_pc        = 32'h0;
      mem_req_ready = 1'b1;
      mem_rsp_valid = 1'b0;
      mem_rdata     = 32'h0;
      instr_ready   = 1'b0;

      // ---- reset state ----
      tick();
      tick();
      check_empty("reset");
      check_eq("reset.mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
      req_valid = 1'b0;
      rst       = 1'b1;
      #1;

      // ---- 1: streaming, 1-cycle memory ----
      instr_ready = 1'b1;
      req_valid = 1'b1; req_pc = 32'h0;
      #1;
      check_eq("t1.req_ready0", {31'b0, req_ready}, 32'd1);
      check_eq("t1.mem_req_valid0", {31'b0, mem_req_valid}, 32'd1);
      check_eq("t1.mem_addr0", mem_addr, 32'h0);
      tick();
      req_pc = 32'h4;
      mem_rsp_valid = 1'b1; mem_rdata = 32'h0050_0093;
      tick();
      check_head("t1.h0", 32'h0, 32'h0050_0093);
      req_pc = 32'h8;
      mem_rsp_valid = 1'b1; mem_rdata = 32'h00A0_0113;
      #1;
      check_eq("t1.req_ready_full", {31'b0, req_ready}, 32'd0);
      tick();
      check_head("t1.h1", 32'h4, 32'h00A0_0113);
      mem_rsp_valid = 1'b0;
      #1;
      check_eq("t1.req_ready8", {31'b0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
      check_eq("t1.gap.valid", {31'b0, instr_valid}, 32'd0);
      respond(32'h0020_81B3);
      check_head("t1.h2", 32'h8, 32'h0020_81B3);
      tick();
      check_empty("t1.drained");

      // ---- 2: back-pressure, instr_ready=0 ----
      instr_ready = 1'b0;
      issue_req(32'h200);
      req_valid = 1'b1; req_pc = 32'h204;
      mem_rsp_valid = 1'b1; mem_rdata = 32'h1111_1111;
      tick();
      req_valid = 1'b0;
      respond(32'h2222_2222);
      req_valid = 1'b1; req_pc = 32'h208;
      #1;
      check_eq("t2.req_ready_full", {31'b0, req_ready}, 32'd0);
      check_eq("t2.mem_req_valid_full", {31'b0, mem_req_valid}, 32'd0);
      check_head("t2.h0", 32'h200, 32'h1111_1111);
      instr_ready = 1'b1;
      tick();
      instr_ready = 1'b0;
      req_valid = 1'b0;
      #1;
      check_eq("t2.req_ready_after_pop", {31'b0, req_ready}, 32'd1);
      check_head("t2.h1", 32'h204, 32'h2222_2222);
      instr_ready = 1'b1;
      tick();
      check_empty("t2.drained");

      // ---- 3: flush with two in flight ----
      issue_req(32'h10);
      issue_req(32'h14);
      flush = 1'b1;
      req_valid = 1'b1; req_pc = 32'h18;
      #1;
      check_eq("t3.req_ready_flush", {31'b0, req_ready}, 32'd0);
      check_eq("t3.mem_req_valid_flush", {31'b0, mem_req_valid}, 32'd0);
      tick();
      flush = 1'b0;
      req_valid = 1'b0;
      respond(32'hDEAD_0010);
      check_eq("t3.drop0.valid", {31'b0, instr_valid}, 32'd0);
      req_valid = 1'b1; req_pc = 32'h100;
      mem_rsp_valid = 1'b1; mem_rdata = 32'hDEAD_0014;
      #1;
      check_eq("t3.req_ready_pending_drop", {31'b0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
      mem_rsp_valid = 1'b0;
      check_eq("t3.drop1.valid", {31'b0, instr_valid}, 32'd0);
      respond(32'h0000_0013);
      check_head("t3.new", 32'h100, 32'h0000_0013);
      tick();
      check_empty("t3.drained");

      // ---- 4: flush in the same cycle as a response ----
      issue_req(32'h20);
      issue_req(32'h24);
      flush = 1'b1;
      mem_rsp_valid = 1'b1; mem_rdata = 32'hBAD0_0020;
      tick();
      flush = 1'b0;
      mem_rsp_valid = 1'b0;
      check_eq("t4.after_flush.valid", {31'b0, instr_valid}, 32'd0);
      respond(32'hBAD0_0024);
      check_eq("t4.after_drop.valid", {31'b0, instr_valid}, 32'd0);
      req_valid = 1'b1; req_pc = 32'h28;
      #1;
      check_eq("t4.req_ready", {31'b0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
      respond(32'h0010_0093);
      check_head("t4.new", 32'h28, 32'h0010_0093);
      tick();
      check_empty("t4.drained");

      // ---- 5: memory stalls for 3 cycles ----
      instr_ready = 1'b0;
      mem_req_ready = 1'b0;
      req_valid = 1'b1; req_pc = 32'h40;
      for (int i = 0; i < 3; i++) begin
         #1;
         check_eq($sformatf("t5.stall%0d.req_ready", i), {31'b0, req_ready}, 32'd0);
         check_eq($sformatf("t5.stall%0d.mem_req_valid", i), {31'b0, mem_req_valid}, 32'd1);
         tick();
      end
      mem_req_ready = 1'b1;
      #1;
      check_eq("t5.accept.req_ready", {31'b0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
      respond(32'h0000_A0B7);
      check_head("t5.h", 32'h40, 32'h0000_A0B7);
      // A single accept leaves one free credit; a double accept leaves none
      check_eq("t5.single_accept", {31'b0, req_ready}, 32'd1);
      instr_ready = 1'b1;
      tick();
      check_empty("t5.drained");

      // ---- 6: asynchronous reset mid-stream ----
      instr_ready = 1'b0;
      issue_req(32'h80);
      req_valid = 1'b1; req_pc = 32'h84;
      mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0297;
      tick();
      req_valid = 1'b0;
      mem_rsp_valid = 1'b0;
      check_head("t6.pre", 32'h80, 32'h0000_0297);
      req_valid = 1'b1; req_pc = 32'h88;
      #2;
      rst = 1'b0;
      #1;
      check_empty("t6.async");
      check_eq("t6.async.mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
      req_valid = 1'b0;
      tick();
      rst = 1'b1;
      instr_ready = 1'b1;
      req_valid = 1'b1; req_pc = 32'h0;
      #1;
      check_eq("t6.post.mem_req_valid", {31'b0, mem_req_valid}, 32'd1);
      check_eq("t6.post.req_ready", {31'b0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
      respond(32'h0000_0513);
      check_head("t6.post", 32'h0, 32'h0000_0513);
      tick();
      check_empty("t6.drained");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
